bs_arbiter: RTL and testbench

//  Shares one binary-search engine (32-entry x 8-bit RAM, 5-bit index) among N_REQ requesters.

---
 rtl/bs_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_bs_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_arbiter.sv
// Round-robin arbiter that shares one binary-search engine among N_REQ requesters.
// A single search is in flight at a time. The engine's done flags must read clear for
// SETTLE cycles before start is raised and again after the response. A watchdog aborts
// any search that runs for TIMEOUT cycles.
module bs_arbiter #(
    parameter int N_REQ   = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_num,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   resp_valid,
    output logic               resp_found,
    output logic [4:0]         resp_index,
    output logic               resp_timeout,
    output logic               busy,
    output logic [7:0]         bs_num,
    output logic               bs_start,
    input  logic [4:0]         bs_index,
    input  logic               bs_found,
    input  logic               bs_not_found
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SEARCH  = 3'd2,
        RESPOND = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic               resp_found_q, resp_found_d;
    logic [4:0]         resp_index_q, resp_index_d;
    logic               resp_timeout_q, resp_timeout_d;
    logic [7:0]         bs_num_q, bs_num_d;
    logic               bs_start_q, bs_start_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [WD_W-1:0]    wd_q, wd_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_id;
    logic               flags_clear;

    assign flags_clear = !bs_found && !bs_not_found;

    // Pick the first requester at or after the RR pointer, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(rr_q) + i) % N_REQ]) begin
                win_found = 1'b1;
                win_id    = IDX_W'((int'(rr_q) + i) % N_REQ);
            end
        end
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        id_d           = id_q;
        grant_d        = grant_q;
        resp_valid_d   = '0;
        resp_found_d   = resp_found_q;
        resp_index_d   = resp_index_q;
        resp_timeout_d = resp_timeout_q;
        bs_num_d       = bs_num_q;
        bs_start_d     = 1'b0;
        settle_d       = settle_q;
        wd_d           = wd_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    id_d     = win_id;
                    bs_num_d = req_num[int'(win_id) * 8 +: 8];
                    grant_d  = N_REQ'(1) << win_id;
                    settle_d = '0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (!flags_clear) begin
                    settle_d = '0;
                end else if (settle_q == SET_W'(SETTLE - 1)) begin
                    settle_d   = '0;
                    wd_d       = '0;
                    bs_start_d = 1'b1;
                    state_d    = SEARCH;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            SEARCH: begin
                bs_start_d = 1'b1;
                // Saturate rather than wrap so a stuck count can never look fresh.
                if (wd_q < WD_W'(TIMEOUT))
                    wd_d = wd_q + 1'b1;
                // A done flag on the same edge as the timeout takes priority.
                if (bs_found) begin
                    resp_found_d   = 1'b1;
                    resp_index_d   = bs_index;
                    resp_timeout_d = 1'b0;
                end else if (bs_not_found) begin
                    resp_found_d   = 1'b0;
                    resp_index_d   = '0;
                    resp_timeout_d = 1'b0;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    resp_found_d   = 1'b0;
                    resp_index_d   = '0;
                    resp_timeout_d = 1'b1;
                end
                if (bs_found || bs_not_found || (wd_q == WD_W'(TIMEOUT - 1))) begin
                    bs_start_d   = 1'b0;
                    resp_valid_d = grant_q;
                    state_d      = RESPOND;
                end
            end
            RESPOND: begin
                grant_d  = '0;
                rr_d     = (id_q == IDX_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                settle_d = '0;
                state_d  = RECOVER;
            end
            RECOVER: begin
                if (!flags_clear) begin
                    settle_d = '0;
                end else if (settle_q == SET_W'(SETTLE - 1)) begin
                    settle_d = '0;
                    state_d  = IDLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, including the engine start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            rr_q           <= '0;
            id_q           <= '0;
            grant_q        <= '0;
            resp_valid_q   <= '0;
            resp_found_q   <= 1'b0;
            resp_index_q   <= '0;
            resp_timeout_q <= 1'b0;
            bs_num_q       <= '0;
            bs_start_q     <= 1'b0;
            settle_q       <= '0;
            wd_q           <= '0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            id_q           <= id_d;
            grant_q        <= grant_d;
            resp_valid_q   <= resp_valid_d;
            resp_found_q   <= resp_found_d;
            resp_index_q   <= resp_index_d;
            resp_timeout_q <= resp_timeout_d;
            bs_num_q       <= bs_num_d;
            bs_start_q     <= bs_start_d;
            settle_q       <= settle_d;
            wd_q           <= wd_d;
        end
    end

    assign grant        = grant_q;
    assign resp_valid   = resp_valid_q;
    assign resp_found   = resp_found_q;
    assign resp_index   = resp_index_q;
    assign resp_timeout = resp_timeout_q;
    assign bs_num       = bs_num_q;
    assign bs_start     = bs_start_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_bs_arbiter.sv
// Directed bench for bs_arbiter: a per-cycle vector table for a single found search,
// then hand-written sequences for fairness, not-found, timeout, reset and recovery.
module tb_bs_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_num;
    logic [3:0]  grant;
    logic [3:0]  resp_valid;
    logic        resp_found;
    logic [4:0]  resp_index;
    logic        resp_timeout;
    logic        busy;
    logic [7:0]  bs_num;
    logic        bs_start;
    logic [4:0]  bs_index;
    logic        bs_found;
    logic        bs_not_found;

    int n_chk;
    int n_fail;
    int rv_seen;

    bs_arbiter #(.N_REQ(4), .SETTLE(2), .TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_num      (req_num),
        .grant        (grant),
        .resp_valid   (resp_valid),
        .resp_found   (resp_found),
        .resp_index   (resp_index),
        .resp_timeout (resp_timeout),
        .busy         (busy),
        .bs_num       (bs_num),
        .bs_start     (bs_start),
        .bs_index     (bs_index),
        .bs_found     (bs_found),
        .bs_not_found (bs_not_found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [7:0] num0;
        logic       fnd;
        logic       nf;
        logic [4:0] idx;
        logic [3:0] e_grant;
        logic [3:0] e_rv;
        logic       e_found;
        logic [4:0] e_index;
        logic       e_to;
        logic       e_busy;
        logic       e_start;
        logic [7:0] e_num;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (resp_valid != 4'b0) rv_seen++;
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (bs_start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({name, "_start_seen"}, {31'b0, bs_start}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        chk({name, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cnt;
        logic [3:0] eg;
        logic [7:0] en;

        n_chk = 0;
        n_fail = 0;
        rv_seen = 0;
        reset = 1'b1;
        req = 4'b0;
        req_num = {8'd44, 8'd33, 8'd22, 8'd11};
        bs_index = 5'd0;
        bs_found = 1'b0;
        bs_not_found = 1'b0;

        //                 req  num  f  nf idx   grant rv  fnd idx to busy start num
        tbl[0] = '{4'b0001, 8'd11, 0, 0, 5'd0, 4'b0001, 4'b0000, 0, 5'd0, 0, 1, 0, 8'd11};
        tbl[1] = '{4'b0001, 8'd11, 0, 0, 5'd0, 4'b0001, 4'b0000, 0, 5'd0, 0, 1, 0, 8'd11};
        tbl[2] = '{4'b0001, 8'd11, 0, 0, 5'd0, 4'b0001, 4'b0000, 0, 5'd0, 0, 1, 1, 8'd11};
        tbl[3] = '{4'b0001, 8'd11, 1, 0, 5'd5, 4'b0001, 4'b0001, 1, 5'd5, 0, 1, 0, 8'd11};
        tbl[4] = '{4'b0000, 8'd11, 0, 0, 5'd0, 4'b0000, 4'b0000, 1, 5'd5, 0, 1, 0, 8'd11};
        tbl[5] = '{4'b0000, 8'd99, 0, 0, 5'd0, 4'b0000, 4'b0000, 1, 5'd5, 0, 1, 0, 8'd11};
        tbl[6] = '{4'b0000, 8'd99, 0, 0, 5'd0, 4'b0000, 4'b0000, 1, 5'd5, 0, 0, 0, 8'd11};
        tbl[7] = '{4'b0000, 8'd99, 0, 0, 5'd0, 4'b0000, 4'b0000, 1, 5'd5, 0, 0, 0, 8'd11};

        // Reset state
        #1;
        chk("rst_grant", {28'b0, grant}, 32'd0);
        chk("rst_resp_valid", {28'b0, resp_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_bs_start", {31'b0, bs_start}, 32'd0);
        chk("rst_bs_num", {24'b0, bs_num}, 32'd0);
        #12 reset = 1'b0;

        // Test 1: single found search, cycle by cycle
        for (int i = 0; i < 8; i++) begin
            req          = tbl[i].req;
            req_num      = {8'd44, 8'd33, 8'd22, tbl[i].num0};
            bs_found     = tbl[i].fnd;
            bs_not_found = tbl[i].nf;
            bs_index     = tbl[i].idx;
            step();
            chk($sformatf("t1_grant_%0d", i), {28'b0, grant}, {28'b0, tbl[i].e_grant});
            chk($sformatf("t1_rv_%0d", i), {28'b0, resp_valid}, {28'b0, tbl[i].e_rv});
            chk($sformatf("t1_found_%0d", i), {31'b0, resp_found}, {31'b0, tbl[i].e_found});
            chk($sformatf("t1_index_%0d", i), {27'b0, resp_index}, {27'b0, tbl[i].e_index});
            chk($sformatf("t1_to_%0d", i), {31'b0, resp_timeout}, {31'b0, tbl[i].e_to});
            chk($sformatf("t1_busy_%0d", i), {31'b0, busy}, {31'b0, tbl[i].e_busy});
            chk($sformatf("t1_start_%0d", i), {31'b0, bs_start}, {31'b0, tbl[i].e_start});
            chk($sformatf("t1_num_%0d", i), {24'b0, bs_num}, {24'b0, tbl[i].e_num});
        end

        // Test 3: not found clears the previous found result
        req_num = {8'd44, 8'd55, 8'd22, 8'd11};
        req = 4'b0100;
        wait_start("t3");
        chk("t3_grant", {28'b0, grant}, 32'b0100);
        chk("t3_num", {24'b0, bs_num}, 32'd55);
        req = 4'b0000;
        bs_not_found = 1'b1;
        step();
        bs_not_found = 1'b0;
        chk("t3_rv", {28'b0, resp_valid}, 32'b0100);
        chk("t3_found", {31'b0, resp_found}, 32'd0);
        chk("t3_index", {27'b0, resp_index}, 32'd0);
        chk("t3_to", {31'b0, resp_timeout}, 32'd0);
        wait_idle("t3");

        // Test 2: fairness from a freshly reset RR pointer
        reset = 1'b1;
        #1;
        reset = 1'b0;
        req_num = {8'd44, 8'd33, 8'd22, 8'd11};
        req = 4'b1111;
        rv_seen = 0;
        for (int s = 0; s < 5; s++) begin
            eg = 4'b0001 << (s % 4);
            en = 8'd11 * 8'((s % 4) + 1);
            wait_start($sformatf("t2_%0d", s));
            chk($sformatf("t2_grant_%0d", s), {28'b0, grant}, {28'b0, eg});
            chk($sformatf("t2_num_%0d", s), {24'b0, bs_num}, {24'b0, en});
            bs_not_found = 1'b1;
            if (s == 4) req = 4'b0000;
            step();
            bs_not_found = 1'b0;
            chk($sformatf("t2_rv_%0d", s), {28'b0, resp_valid}, {28'b0, eg});
        end
        wait_idle("t2");
        chk("t2_rv_count", rv_seen, 32'd5);

        // Test 4: watchdog abort after exactly TIMEOUT cycles of start
        req = 4'b0001;
        wait_start("t4");
        req = 4'b0000;
        cnt = 1;
        for (int n = 0; n < 40; n++) begin
            step();
            if (bs_start === 1'b1) cnt++;
            else break;
        end
        chk("t4_start_cycles", cnt, 32'd16);
        chk("t4_rv", {28'b0, resp_valid}, 32'b0001);
        chk("t4_to", {31'b0, resp_timeout}, 32'd1);
        chk("t4_found", {31'b0, resp_found}, 32'd0);
        chk("t4_index", {27'b0, resp_index}, 32'd0);
        wait_idle("t4");

        // Done flag on the same edge as the timeout: done wins
        req = 4'b0010;
        wait_start("t4b");
        req = 4'b0000;
        repeat (15) step();
        chk("t4b_still_searching", {31'b0, bs_start}, 32'd1);
        bs_found = 1'b1;
        bs_index = 5'd9;
        step();
        bs_found = 1'b0;
        chk("t4b_rv", {28'b0, resp_valid}, 32'b0010);
        chk("t4b_found", {31'b0, resp_found}, 32'd1);
        chk("t4b_index", {27'b0, resp_index}, 32'd9);
        chk("t4b_to", {31'b0, resp_timeout}, 32'd0);
        wait_idle("t4b");

        // Test 5: asynchronous reset in the middle of a search
        req_num = {8'd44, 8'd33, 8'd22, 8'd77};
        req = 4'b0001;
        wait_start("t5");
        step();
        reset = 1'b1;
        #1;
        chk("t5_grant", {28'b0, grant}, 32'd0);
        chk("t5_rv", {28'b0, resp_valid}, 32'd0);
        chk("t5_found", {31'b0, resp_found}, 32'd0);
        chk("t5_index", {27'b0, resp_index}, 32'd0);
        chk("t5_to", {31'b0, resp_timeout}, 32'd0);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_start", {31'b0, bs_start}, 32'd0);
        chk("t5_num", {24'b0, bs_num}, 32'd0);
        #1 reset = 1'b0;
        req = 4'b0110;
        step();
        chk("t5_grant_after", {28'b0, grant}, 32'b0010);
        req = 4'b0000;
        wait_start("t5b");
        bs_not_found = 1'b1;
        step();
        bs_not_found = 1'b0;
        chk("t5_dropped_rv", {28'b0, resp_valid}, 32'b0010);
        wait_idle("t5");

        // Test 6: engine holds found after start drops
        req = 4'b0001;
        wait_start("t6");
        bs_found = 1'b1;
        bs_index = 5'd3;
        step();
        chk("t6_rv", {28'b0, resp_valid}, 32'b0001);
        chk("t6_index", {27'b0, resp_index}, 32'd3);
        for (int n = 1; n <= 3; n++) begin
            step();
            chk($sformatf("t6_hold_grant_%0d", n), {28'b0, grant}, 32'd0);
            chk($sformatf("t6_hold_busy_%0d", n), {31'b0, busy}, 32'd1);
        end
        bs_found = 1'b0;
        step();
        chk("t6_settle1_grant", {28'b0, grant}, 32'd0);
        chk("t6_settle1_busy", {31'b0, busy}, 32'd1);
        step();
        chk("t6_idle_grant", {28'b0, grant}, 32'd0);
        chk("t6_idle_busy", {31'b0, busy}, 32'd0);
        step();
        chk("t6_regrant", {28'b0, grant}, 32'b0001);
        req = 4'b0000;
        wait_start("t6b");
        bs_not_found = 1'b1;
        step();
        bs_not_found = 1'b0;
        wait_idle("t6b");

        // Done flags while idle are ignored
        rv_seen = 0;
        bs_found = 1'b1;
        bs_not_found = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk($sformatf("t6_idle_flags_busy_%0d", n), {31'b0, busy}, 32'd0);
        end
        bs_found = 1'b0;
        bs_not_found = 1'b0;
        step();
        chk("t6_idle_flags_rv", rv_seen, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
